cgra_config_receiver: RTL



---
 rtl/cgra_config_pkg.sv | 32 +++
 rtl/cgra_config_fifo.sv | 73 +++++++
 rtl/cgra_config_receiver.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cgra_config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cgra_config_pkg
// Purpose  : Shared address-field slices, FSM state and buffered word type
//            for the CGRA tile configuration receiver.
// Revision : 1.0 - initial release
// ============================================================================
package cgra_config_pkg;

   localparam int ADDR_REG_MSB  = 31;
   localparam int ADDR_REG_LSB  = 24;
   localparam int ADDR_FEAT_MSB = 23;
   localparam int ADDR_FEAT_LSB = 16;
   localparam int ADDR_TILE_MSB = 15;
   localparam int ADDR_TILE_LSB = 0;

   typedef enum logic [1:0] {
      CFG_IDLE  = 2'd0,
      CFG_LOAD  = 2'd1,
      CFG_DRAIN = 2'd2,
      CFG_DONE  = 2'd3
   } cfg_state_t;

   // "reg" is a keyword, so the register field is named reg_idx.
   typedef struct packed {
      logic [7:0]  reg_idx;
      logic [7:0]  feature;
      logic [31:0] data;
   } cfg_word_t;

endpackage : cgra_config_pkg
`default_nettype wire

// File: rtl/cgra_config_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cgra_config_fifo
// Purpose  : First-word fall-through FIFO of configuration words.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_config_fifo
   import cgra_config_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_in,
   input  logic                     reset_in,
   input  logic                     push,
   input  cfg_word_t                wr_word,
   input  logic                     pop,
   output cfg_word_t                rd_word,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                   c_PTR_W    = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]     c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

   cfg_word_t              r_mem [DEPTH];
   logic [c_PTR_W-1:0]     r_wr_ptr;
   logic [c_PTR_W-1:0]     r_rd_ptr;
   logic [c_PTR_W:0]       r_count;
   logic                   w_push_ok;
   logic                   w_pop_ok;

   assign empty   = (r_count == '0);
   assign full    = (r_count == c_FULL_CNT);
   assign count   = r_count;
   assign rd_word = r_mem[r_rd_ptr];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop_ok  = pop && !empty;
   assign w_push_ok = push && (!full || w_pop_ok);

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push_ok) begin
         r_mem[r_wr_ptr] <= wr_word;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : cgra_config_fifo
`default_nettype wire

// File: rtl/cgra_config_receiver.sv
`default_nettype none
// ============================================================================
// Module   : cgra_config_receiver
// Purpose  : Tile-side config bus responder: address filter, word buffer,
//            end-of-configuration detection and overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module cgra_config_receiver
   import cgra_config_pkg::*;
#(
   parameter logic [15:0] TILE_ID     = 16'h0000,
   parameter logic [15:0] BCAST_ID    = 16'hFFFF,
   parameter int          DEPTH       = 4,
   parameter int          IDLE_CYCLES = 8
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [31:0] config_addr_in,
   input  logic [31:0] config_data_in,
   output logic        cfg_wr_valid,
   input  logic        cfg_wr_ready,
   output logic [7:0]  cfg_wr_feature,
   output logic [7:0]  cfg_wr_reg,
   output logic [31:0] cfg_wr_data,
   output logic [15:0] cfg_wr_count,
   output logic        overflow_err,
   output logic        config_done_out
);

   localparam int                  c_IDLE_W    = $clog2(IDLE_CYCLES + 1);
   localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = c_IDLE_W'(IDLE_CYCLES);
   localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_CYCLES - 1);

   logic                   w_addr_nz;
   logic [15:0]            w_tile;
   logic                   w_match;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_empty;
   logic [$clog2(DEPTH):0] w_fifo_count;
   cfg_word_t              w_push_word;
   cfg_word_t              w_head;
   cfg_state_t             r_state;
   cfg_state_t             w_state_next;
   logic [c_IDLE_W-1:0]    r_idle_cnt;
   logic [15:0]            r_wr_count;
   logic                   r_overflow;
   logic                   w_done;

   assign w_addr_nz   = (config_addr_in != '0);
   assign w_tile      = config_addr_in[ADDR_TILE_MSB:ADDR_TILE_LSB];
   assign w_match     = w_addr_nz && ((w_tile == TILE_ID) || (w_tile == BCAST_ID));
   assign w_push_word = {config_addr_in[ADDR_REG_MSB:ADDR_REG_LSB],
                         config_addr_in[ADDR_FEAT_MSB:ADDR_FEAT_LSB],
                         config_data_in};
   assign w_pop       = cfg_wr_valid && cfg_wr_ready;

   cgra_config_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .push     (w_match),
      .wr_word  (w_push_word),
      .pop      (w_pop),
      .rd_word  (w_head),
      .full     (w_full),
      .empty    (w_empty),
      .count    (w_fifo_count)
   );

   assign cfg_wr_valid    = !w_empty;
   assign cfg_wr_reg      = w_head.reg_idx;
   assign cfg_wr_feature  = w_head.feature;
   assign cfg_wr_data     = w_head.data;
   assign cfg_wr_count    = r_wr_count;
   assign overflow_err    = r_overflow;
   assign config_done_out = w_done;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_idle_cnt <= '0;
         r_wr_count <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_addr_nz) begin
            r_idle_cnt <= '0;
         end else if (r_idle_cnt != c_IDLE_MAX) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
         end
         if (w_pop && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
         end
         if (w_match && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_state <= CFG_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Zero-address cycles only count toward completion once a load has begun.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         CFG_IDLE: begin
            if (w_addr_nz) w_state_next = CFG_LOAD;
         end
         CFG_LOAD: begin
            if (!w_addr_nz && (r_idle_cnt == c_IDLE_LAST)) w_state_next = CFG_DRAIN;
         end
         CFG_DRAIN: begin
            if (w_addr_nz)                 w_state_next = CFG_LOAD;
            else if (w_fifo_count == '0)   w_state_next = CFG_DONE;
         end
         CFG_DONE: begin
            if (w_addr_nz) w_state_next = CFG_LOAD;
         end
         default: w_state_next = CFG_IDLE;
      endcase
   end

   always_comb begin
      w_done = (r_state == CFG_DONE);
   end

endmodule : cgra_config_receiver
`default_nettype wire
